mult_div_unit: RTL and testbench

//  Multiply/divide unit in the EX stage. Consumes MDU_Operation from the instruction decoder and the forwarded rs/rt values.

---
 rtl/mult_div_unit_if.sv | 20 ++
 rtl/mult_div_unit.sv | 139 +++++++++++++
 tb/tb_mult_div_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// EX-stage MDU handshake: decoded op and operands in, start/busy and HI/LO out.
interface mult_div_unit_if;
  logic [3:0]  MDU_Operation;
  logic [31:0] Op1;
  logic [31:0] Op2;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDU_Operation, Op1, Op2,
    input  Start, Busy, HI, LO
  );

  modport slave (
    input  MDU_Operation, Op1, Op2,
    output Start, Busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO for the EX stage.
// Optional MDU_DIV0_GUARD_EN: div/divu by zero never starts.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam logic [3:0] MDU_NOOP  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_READ  = 4'd5;
  localparam logic [3:0] MDU_MTHI  = 4'd6;
  localparam logic [3:0] MDU_MTLO  = 4'd7;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES)
                      ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [31:0]   hi, lo;
  logic [31:0]   sh_hi, sh_lo;

  logic [3:0]  op;
  logic [31:0] a, b;
  assign op = bus.MDU_Operation;
  assign a  = bus.Op1;
  assign b  = bus.Op2;

  logic is_mult, is_multu, is_div, is_divu;
  logic is_md, b_zero, start;
  assign is_mult  = (op == MDU_MULT);
  assign is_multu = (op == MDU_MULTU);
  assign is_div   = (op == MDU_DIV);
  assign is_divu  = (op == MDU_DIVU);
  assign is_md    = is_mult | is_multu | is_div | is_divu;
  assign b_zero   = (b == 32'd0);

`ifdef MDU_DIV0_GUARD_EN
  assign start = (state == IDLE) & is_md
               & ~((is_div | is_divu) & b_zero);
`else
  assign start = (state == IDLE) & is_md;
`endif

  logic [63:0] sa, sb, ua, ub, prod_s, prod_u;
  assign sa     = {{32{a[31]}}, a};
  assign sb     = {{32{b[31]}}, b};
  assign ua     = {32'd0, a};
  assign ub     = {32'd0, b};
  assign prod_s = sa * sb;
  assign prod_u = ua * ub;

  // Signed divide via magnitudes avoids the INT_MIN/-1 overflow case
  logic [31:0] mag_a, mag_b, dvs_s, dvs_u;
  logic [31:0] sq, sr, uq, ur, qs, rs;
  assign mag_a = a[31] ? (~a + 32'd1) : a;
  assign mag_b = b[31] ? (~b + 32'd1) : b;
  assign dvs_s = b_zero ? 32'd1 : mag_b;
  assign dvs_u = b_zero ? 32'd1 : b;
  assign sq    = mag_a / dvs_s;
  assign sr    = mag_a % dvs_s;
  assign uq    = a / dvs_u;
  assign ur    = a % dvs_u;
  assign qs    = (a[31] ^ b[31]) ? (~sq + 32'd1) : sq;
  assign rs    = a[31] ? (~sr + 32'd1) : sr;

  logic [31:0] res_hi, res_lo;
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    unique case (1'b1)
      is_mult:  {res_hi, res_lo} = prod_s;
      is_multu: {res_hi, res_lo} = prod_u;
      is_div: begin
        res_hi = b_zero ? a : rs;
        res_lo = b_zero ? 32'hFFFF_FFFF : qs;
      end
      is_divu: begin
        res_hi = b_zero ? a : ur;
        res_lo = b_zero ? 32'hFFFF_FFFF : uq;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      sh_hi <= '0;
      sh_lo <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sh_hi <= res_hi;
            sh_lo <= res_lo;
            cnt   <= (is_mult | is_multu)
                   ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy  <= 1'b1;
            state <= BUSY;
          end else if (op == MDU_MTHI) begin
            hi <= a;
          end else if (op == MDU_MTLO) begin
            lo <= a;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi    <= sh_hi;
            lo    <= sh_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Start = start;
  assign bus.Busy  = busy;
  assign bus.HI    = hi;
  assign bus.LO    = lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic, HI/LO moves,
// async reset and divide-by-zero handling.
module tb_mult_div_unit;
  localparam logic [3:0] NOOP  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] READ  = 4'd5;
  localparam logic [3:0] MTHI  = 4'd6;
  localparam logic [3:0] MTLO  = 4'd7;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mult_div_unit_if m ();

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] op, logic [31:0] x,
                       logic [31:0] y);
    m.MDU_Operation = op;
    m.Op1 = x;
    m.Op2 = y;
  endtask

  task automatic run_op(string tag, logic [3:0] op,
                        logic [31:0] x, logic [31:0] y,
                        int n, logic [31:0] eh,
                        logic [31:0] el);
    logic [31:0] oh, ol;
    oh = m.HI;
    ol = m.LO;
    drive(op, x, y);
    #1;
    check({tag, "_start0"}, 32'(m.Start), 32'd1);
    check({tag, "_busy0"}, 32'(m.Busy), 32'd0);
    step();
    drive(NOOP, 32'd0, 32'd0);
    for (int i = 1; i <= n; i++) begin
      #1;
      check({tag, "_busy"}, 32'(m.Busy), 32'd1);
      check({tag, "_nostart"}, 32'(m.Start), 32'd0);
      check({tag, "_oldhi"}, m.HI, oh);
      check({tag, "_oldlo"}, m.LO, ol);
      step();
    end
    drive(READ, 32'd0, 32'd0);
    #1;
    check({tag, "_busyend"}, 32'(m.Busy), 32'd0);
    check({tag, "_startend"}, 32'(m.Start), 32'd0);
    check({tag, "_hi"}, m.HI, eh);
    check({tag, "_lo"}, m.LO, el);
    drive(NOOP, 32'd0, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(NOOP, 32'd0, 32'd0);
    step();
    step();
    check("rst_busy", 32'(m.Busy), 32'd0);
    check("rst_start", 32'(m.Start), 32'd0);
    check("rst_hi", m.HI, 32'd0);
    check("rst_lo", m.LO, 32'd0);
    reset = 1'b0;
    step();

    drive(MTHI, 32'h1234_5678, 32'd0);
    #1;
    check("mthi_nostart", 32'(m.Start), 32'd0);
    step();
    check("mthi_hi", m.HI, 32'h1234_5678);
    check("mthi_lo", m.LO, 32'd0);
    drive(MTLO, 32'h0000_0055, 32'd0);
    step();
    check("mtlo_lo", m.LO, 32'h0000_0055);
    check("mtlo_hi", m.HI, 32'h1234_5678);
    drive(NOOP, 32'd0, 32'd0);
    step();

    // Reset in cycle 3 of a divide
    drive(DIV, 32'd100, 32'd7);
    step();
    drive(NOOP, 32'd0, 32'd0);
    check("mid_busy1", 32'(m.Busy), 32'd1);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(m.Busy), 32'd0);
    check("mid_rst_hi", m.HI, 32'd0);
    check("mid_rst_lo", m.LO, 32'd0);
    step();
    reset = 1'b0;
    step();

    run_op("divu72", DIVU, 32'd7, 32'd2, 10,
           32'd1, 32'd3);
    run_op("mult", MULT, 32'hFFFF_FFFF, 32'd2, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 5,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           10, 32'd0, 32'h8000_0000);
    run_op("mult_mix", MULT, 32'hFFFF_FFFD, 32'd7, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // MTLO arriving while busy must be ignored
    drive(MULT, 32'd3, 32'd4);
    step();
    drive(MTLO, 32'hDEAD_BEEF, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      #1;
      check("mtlo_busy_lo", m.LO, 32'hFFFF_FFEB);
      check("mtlo_busy_busy", 32'(m.Busy), 32'd1);
      step();
    end
    check("mtlo_busy_res_lo", m.LO, 32'h0000_000C);
    check("mtlo_busy_res_hi", m.HI, 32'd0);
    check("mtlo_busy_done", 32'(m.Busy), 32'd0);
    drive(NOOP, 32'd0, 32'd0);
    step();
    check("mtlo_after_lo", m.LO, 32'h0000_000C);

`ifdef MDU_DIV0_GUARD_EN
    drive(DIVU, 32'h0000_ABCD, 32'd0);
    #1;
    check("div0_start", 32'(m.Start), 32'd0);
    step();
    check("div0_busy", 32'(m.Busy), 32'd0);
    check("div0_hi", m.HI, 32'd0);
    check("div0_lo", m.LO, 32'h0000_000C);
    drive(DIV, 32'h0000_ABCD, 32'd0);
    #1;
    check("div0s_start", 32'(m.Start), 32'd0);
    step();
    check("div0s_busy", 32'(m.Busy), 32'd0);
    drive(NOOP, 32'd0, 32'd0);
`else
    run_op("div0", DIVU, 32'h0000_ABCD, 32'd0, 10,
           32'h0000_ABCD, 32'hFFFF_FFFF);
    run_op("div0s", DIV, 32'hFFFF_FF00, 32'd0, 10,
           32'hFFFF_FF00, 32'hFFFF_FFFF);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
